ctrl_pipe_reg: RTL and testbench
================================

// Module: ctrl_pipe_reg
// PURPOSE
//   Parametrised multi-stage pipeline register for decoded control bundles.
//   Carries the ID-stage control word through DEPTH stages (E, M, W, ...).
//   Adds per-stage valid tracking, stall with upstream back-pressure and bubble insertion,
//   per-stage flush, and a saturating bubble counter at the last stage.
//   Sits between the control decoder and the execute/memory/writeback datapath.
// PARAMETERS
//   CTRL_W   17             control word width (ALUSel4,BSel2,ILoad3,WBSel2,RegWEn,MemRW,PCSel,ASel2,BrUn)
//   DEPTH    3              number of stages; stage 0 = E, stage DEPTH-1 = last; legal range 1..8
//   NOP_CTRL {CTRL_W{1'b0}} control word driven by an invalid stage (RegWEn=0, MemRW=0)
//   CNT_W    16             bubble counter width
// PORTS
//   clk        in  1             rising-edge clock
//   rst        in  1             asynchronous, active-low reset
//   in_valid   in  1             in_ctrl holds a real instruction
//   in_ready   out 1             stage 0 accepts this cycle; = ~hold[0] (combinational)
//   in_ctrl    in  CTRL_W        control word from decode
//   stall      in  DEPTH         stall[k]: stage k must keep its contents
//   flush      in  DEPTH         flush[k]: stage k becomes a bubble at next edge
//   cnt_clr    in  1             synchronous clear of bubble_cnt
//   ctrl_o     out DEPTH*CTRL_W  stage k word at [k*CTRL_W +: CTRL_W]
//   valid_o    out DEPTH         per-stage valid
//   bubble_cnt out CNT_W         count of cycles with valid_o[DEPTH-1]==0
// BEHAVIOUR
//   Reset (rst=0, async): valid_o=0, every stage word=NOP_CTRL, bubble_cnt=0. in_ready = ~hold[0].
//   Hold chain (combinational): hold[DEPTH-1]=stall[DEPTH-1]; hold[k]=stall[k]|hold[k+1].
//   Per-stage update at posedge clk, in priority order:
//     1. flush[k]                  -> valid=0, word=NOP_CTRL (flush beats stall/hold)
//     2. hold[k]                   -> keep valid and word
//     3. k>0 and hold[k-1]         -> bubble (valid=0, NOP_CTRL): upstream held, this stage drains
//     4. k>0                       -> copy stage k-1 valid and word
//     5. k==0                      -> valid=in_valid; word = in_valid ? in_ctrl : NOP_CTRL
//   Latency: an accepted word appears on stage k output k+1 cycles after acceptance, absent holds.
//   Accepted = in_valid & in_ready at a clock edge; word not accepted is not captured and
//     must be held by the producer.
//   Invalid stage never drives anything but NOP_CTRL; stored word is replaced, not masked.
//   A flushed, held stage stays a bubble for the rest of the hold; it does not reload.
//   flush[0] with in_valid=1 and in_ready=1: stage 0 becomes a bubble; in_ready still reads 1,
//     so the producer sees acceptance and the word is discarded (intended: kills wrong-path fetch).
//   bubble_cnt: each edge, cnt_clr -> 0; else if valid_o[DEPTH-1]==0 and not all-ones -> +1;
//     else hold. Saturates at 2^CNT_W-1. Counts the pre-edge valid_o value.
//   Simultaneous cnt_clr and count event: clear wins.
//   Reset mid-operation: all stages cleared immediately (async); in-flight words lost.
//   No X propagation: every flop reset; stall/flush assumed known after reset release.
// TESTING
//   1 Reset: rst=0 then release; expect valid_o=3'b000, ctrl_o all NOP_CTRL, bubble_cnt=0, in_ready=1.
//   2 Stream: in_ctrl=17'h1A5A5, 17'h0F0F0, 17'h13333 on three cycles, in_valid=1;
//     stage0/1/2 show 17'h1A5A5 at cycles +1/+2/+3; valid_o reaches 3'b111 at cycle 3.
//   3 Stall: stage1 holding 17'h0F0F0, stall=3'b010 for 2 cycles;
//     expect stage1 hold, stage0 hold with in_ready=0, stage2 shows 2 bubbles, bubble_cnt +2.
//   4 Flush vs stall: stall=3'b001 and flush=3'b001 same edge; stage0 -> valid=0, NOP_CTRL;
//     stays bubble while stall held; reloads in_ctrl on release.
//   5 Counter: CNT_W=4, pipe empty for 20 cycles -> bubble_cnt sticks at 4'hF;
//     cnt_clr pulse with valid_o[2]=0 -> bubble_cnt=0 next edge, then increments.
//   6 Async reset mid-stream with valid_o=3'b111: rst=0 between edges;
//     outputs clear immediately, not at next clk.

Source files
------------

// File: rtl/ctrl_pipe_reg.sv
// Multi-stage pipeline register for decoded control words.
// Each stage tracks its own valid bit and supports stall, flush and bubble insertion. A saturating counter records bubbles at the last stage.
module ctrl_pipe_reg #(
    parameter int                CTRL_W   = 17,
    parameter int                DEPTH    = 3,
    parameter logic [CTRL_W-1:0] NOP_CTRL = '0,
    parameter int                CNT_W    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [CTRL_W-1:0]        in_ctrl,
    input  logic [DEPTH-1:0]         stall,
    input  logic [DEPTH-1:0]         flush,
    input  logic                     cnt_clr,
    output logic [DEPTH*CTRL_W-1:0]  ctrl_o,
    output logic [DEPTH-1:0]         valid_o,
    output logic [CNT_W-1:0]         bubble_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [DEPTH-1:0]             hold;
    logic [DEPTH-1:0]             vld;
    logic [DEPTH-1:0][CTRL_W-1:0] word;
    logic [CNT_W-1:0]             cnt;

    // A stage is frozen when it or any stage downstream of it is stalled.
    always_comb begin
        hold = '0;
        for (int k = 0; k < DEPTH; k++)
            hold[k] = |(stall >> k);
    end

    assign in_ready   = ~hold[0];
    assign valid_o    = vld;
    assign ctrl_o     = word;
    assign bubble_cnt = cnt;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        if (k == 0) begin : g_head
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    vld[k]  <= 1'b0;
                    word[k] <= NOP_CTRL;
                end else if (flush[k]) begin
                    vld[k]  <= 1'b0;
                    word[k] <= NOP_CTRL;
                end else if (!hold[k]) begin
                    vld[k]  <= in_valid;
                    word[k] <= in_valid ? in_ctrl : NOP_CTRL;
                end
            end
        end else begin : g_body
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    vld[k]  <= 1'b0;
                    word[k] <= NOP_CTRL;
                end else if (flush[k]) begin
                    vld[k]  <= 1'b0;
                    word[k] <= NOP_CTRL;
                end else if (hold[k]) begin
                    vld[k]  <= vld[k];
                    word[k] <= word[k];
                end else if (hold[k-1]) begin
                    // Upstream is frozen, so this stage drains as a bubble.
                    vld[k]  <= 1'b0;
                    word[k] <= NOP_CTRL;
                end else begin
                    vld[k]  <= vld[k-1];
                    word[k] <= word[k-1];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else if (cnt_clr)
            cnt <= '0;
        else if (!vld[DEPTH-1] && cnt != '1)
            cnt <= cnt + CNT_ONE;
    end

endmodule

// File: tb/tb_ctrl_pipe_reg.sv
// Bench for ctrl_pipe_reg (DEPTH=3, CNT_W=4). It uses directed table vectors, corner-case sequences and random stimulus.
// The random stimulus is scored against an array-based model of the stage rules.
module tb_ctrl_pipe_reg;
    localparam int W = 17;
    localparam int D = 3;
    localparam int C = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_ctrl;
    logic [D-1:0]   stall;
    logic [D-1:0]   flush;
    logic           cnt_clr;
    logic [D*W-1:0] ctrl_o;
    logic [D-1:0]   valid_o;
    logic [C-1:0]   bubble_cnt;

    ctrl_pipe_reg #(.CTRL_W(W), .DEPTH(D), .NOP_CTRL('0), .CNT_W(C)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_ctrl(in_ctrl), .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
        .ctrl_o(ctrl_o), .valid_o(valid_o), .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: one entry per stage plus the counter value.
    logic         m_vld [D];
    logic [W-1:0] m_word[D];
    int           m_cnt;

    typedef struct {
        logic         iv;
        logic [W-1:0] ic;
        logic [D-1:0] st;
        logic [D-1:0] fl;
        logic         cc;
        logic         rdy;
        logic [D-1:0] ev;
        logic [W-1:0] e0;
        logic [W-1:0] e1;
        logic [W-1:0] e2;
        logic [C-1:0] ecnt;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic frozen(input int k, input logic [D-1:0] st);
        logic f = 1'b0;
        for (int j = k; j < D; j++) f |= st[j];
        return f;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < D; k++) begin
            m_vld[k]  = 1'b0;
            m_word[k] = '0;
        end
        m_cnt = 0;
    endtask

    task automatic model_edge(input logic iv, input logic [W-1:0] ic,
                              input logic [D-1:0] st, input logic [D-1:0] fl, input logic cc);
        logic         nv[D];
        logic [W-1:0] nw[D];
        for (int k = 0; k < D; k++) begin
            if (fl[k])                         begin nv[k] = 1'b0;       nw[k] = '0; end
            else if (frozen(k, st))            begin nv[k] = m_vld[k];   nw[k] = m_word[k]; end
            else if (k > 0 && frozen(k-1, st)) begin nv[k] = 1'b0;       nw[k] = '0; end
            else if (k > 0)                    begin nv[k] = m_vld[k-1]; nw[k] = m_word[k-1]; end
            else                               begin nv[k] = iv;         nw[k] = iv ? ic : '0; end
        end
        if (cc) m_cnt = 0;
        else if (!m_vld[D-1] && m_cnt < (1 << C) - 1) m_cnt++;
        for (int k = 0; k < D; k++) begin
            m_vld[k]  = nv[k];
            m_word[k] = nw[k];
        end
    endtask

    task automatic check_model();
        for (int k = 0; k < D; k++) begin
            chk($sformatf("valid%0d", k), 64'(valid_o[k]), 64'(m_vld[k]));
            chk($sformatf("word%0d", k), 64'(ctrl_o[k*W +: W]), 64'(m_word[k]));
        end
        chk("bubble_cnt", 64'(bubble_cnt), 64'(m_cnt));
    endtask

    // Inputs are applied right after an edge. Ready is sampled before the next edge, and the outputs are compared 1 ns after it.
    task automatic step(input logic iv, input logic [W-1:0] ic, input logic [D-1:0] st,
                        input logic [D-1:0] fl, input logic cc, output logic rdy);
        in_valid = iv; in_ctrl = ic; stall = st; flush = fl; cnt_clr = cc;
        #1;
        rdy = in_ready;
        chk("in_ready", 64'(in_ready), 64'(!frozen(0, st)));
        @(posedge clk);
        model_edge(iv, ic, st, fl, cc);
        #1;
        check_model();
    endtask

    initial begin
        logic r;
        rst = 1'b0; in_valid = 1'b0; in_ctrl = '0; stall = '0; flush = '0; cnt_clr = 1'b0;
        model_reset();
        #12;
        chk("rst_valid", 64'(valid_o), 64'(3'b000));
        chk("rst_ctrl", 64'(ctrl_o), 64'd0);
        chk("rst_cnt", 64'(bubble_cnt), 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd1);
        rst = 1'b1;

        // Rows cover stream fill, a stage-1 stall, flush beating stall, and flush of an accepted word.
        tbl[0] = '{1'b1, 17'h1A5A5, 3'b000, 3'b000, 1'b0, 1'b1, 3'b001, 17'h1A5A5, 17'h0,     17'h0,     4'd1};
        tbl[1] = '{1'b1, 17'h0F0F0, 3'b000, 3'b000, 1'b0, 1'b1, 3'b011, 17'h0F0F0, 17'h1A5A5, 17'h0,     4'd2};
        tbl[2] = '{1'b1, 17'h13333, 3'b000, 3'b000, 1'b0, 1'b1, 3'b111, 17'h13333, 17'h0F0F0, 17'h1A5A5, 4'd3};
        tbl[3] = '{1'b1, 17'h15555, 3'b010, 3'b000, 1'b0, 1'b0, 3'b011, 17'h13333, 17'h0F0F0, 17'h0,     4'd3};
        tbl[4] = '{1'b1, 17'h15555, 3'b010, 3'b000, 1'b0, 1'b0, 3'b011, 17'h13333, 17'h0F0F0, 17'h0,     4'd4};
        tbl[5] = '{1'b1, 17'h15555, 3'b000, 3'b000, 1'b0, 1'b1, 3'b111, 17'h15555, 17'h13333, 17'h0F0F0, 4'd5};
        tbl[6] = '{1'b1, 17'h1ABCD, 3'b001, 3'b001, 1'b0, 1'b0, 3'b100, 17'h0,     17'h0,     17'h13333, 4'd5};
        tbl[7] = '{1'b1, 17'h1ABCD, 3'b001, 3'b000, 1'b0, 1'b0, 3'b000, 17'h0,     17'h0,     17'h0,     4'd5};
        tbl[8] = '{1'b1, 17'h1ABCD, 3'b000, 3'b000, 1'b0, 1'b1, 3'b001, 17'h1ABCD, 17'h0,     17'h0,     4'd6};
        tbl[9] = '{1'b1, 17'h1FFFF, 3'b000, 3'b001, 1'b0, 1'b1, 3'b010, 17'h0,     17'h1ABCD, 17'h0,     4'd7};
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].iv, tbl[i].ic, tbl[i].st, tbl[i].fl, tbl[i].cc, r);
            chk($sformatf("tbl%0d_ready", i), 64'(r), 64'(tbl[i].rdy));
            chk($sformatf("tbl%0d_valid", i), 64'(valid_o), 64'(tbl[i].ev));
            chk($sformatf("tbl%0d_s0", i), 64'(ctrl_o[0*W +: W]), 64'(tbl[i].e0));
            chk($sformatf("tbl%0d_s1", i), 64'(ctrl_o[1*W +: W]), 64'(tbl[i].e1));
            chk($sformatf("tbl%0d_s2", i), 64'(ctrl_o[2*W +: W]), 64'(tbl[i].e2));
            chk($sformatf("tbl%0d_cnt", i), 64'(bubble_cnt), 64'(tbl[i].ecnt));
        end

        // An empty pipe saturates the counter, and a clear then restarts it from zero.
        for (int i = 0; i < 20; i++) step(1'b0, '0, '0, '0, 1'b0, r);
        chk("cnt_sat", 64'(bubble_cnt), 64'hF);
        step(1'b0, '0, '0, '0, 1'b1, r);
        chk("cnt_clr", 64'(bubble_cnt), 64'h0);
        step(1'b0, '0, '0, '0, 1'b0, r);
        chk("cnt_inc1", 64'(bubble_cnt), 64'h1);
        step(1'b0, '0, '0, '0, 1'b0, r);
        chk("cnt_inc2", 64'(bubble_cnt), 64'h2);

        // An async reset between edges must clear the outputs before the next clock.
        step(1'b1, 17'h00111, '0, '0, 1'b0, r);
        step(1'b1, 17'h00222, '0, '0, 1'b0, r);
        step(1'b1, 17'h00333, '0, '0, 1'b0, r);
        chk("pre_rst_valid", 64'(valid_o), 64'(3'b111));
        rst = 1'b0;
        #1;
        chk("async_valid", 64'(valid_o), 64'(3'b000));
        chk("async_ctrl", 64'(ctrl_o), 64'd0);
        chk("async_cnt", 64'(bubble_cnt), 64'd0);
        model_reset();
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        model_edge(in_valid, in_ctrl, stall, flush, cnt_clr);
        check_model();

        // The random phase uses rare stalls, flushes and clears.
        for (int i = 0; i < 400; i++) begin
            logic [D-1:0] st, fl;
            st = '0; fl = '0;
            for (int k = 0; k < D; k++) begin
                st[k] = ($urandom_range(0, 5) == 0);
                fl[k] = ($urandom_range(0, 9) == 0);
            end
            step(1'($urandom_range(0, 3) != 0), W'($urandom), st, fl,
                 1'($urandom_range(0, 24) == 0), r);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
